qtestpd_mem_stream_master: RTL and testbench

- Avalon-MM master that drives the exported on-chip memory slave port (7-bit word address, 8-bit data, read latency 1).
- Converts commands into block transfers:
  - FILL: writes a byte stream into memory.
  - DUMP: reads memory back out as a byte stream.
- Sits directly upstream of the memory. Test logic loads and reads back the memory through it.

---
 rtl/qtestpd_mem_stream_master.sv | 172 +++++++++++++++++
 tb/tb_qtestpd_mem_stream_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qtestpd_mem_stream_master.sv
`default_nettype none
// ============================================================================
// Module   : qtestpd_mem_stream_master
// Purpose  : Avalon-MM master turning FILL/DUMP commands into block transfers
//            against a latency-1 on-chip memory, with byte-stream in/out.
// Revision : 1.0 - initial release
// ============================================================================
module qtestpd_mem_stream_master #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_clken,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [ADDR_W:0] c_one = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_pop_cnt;
  logic              r_cmd_ready;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;

  logic [DATA_W-1:0] r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_occ;
  logic              r_rd_pend;

  logic              w_accept;
  logic              w_out_valid;
  logic              w_pop;
  logic [2:0]        w_inflight;
  logic              w_issue;

  assign w_accept    = r_in_ready & in_valid;
  assign w_out_valid = (r_state == S_DUMP) && (r_occ != 2'd0);
  assign w_pop       = w_out_valid & out_ready;

  // A same-cycle pop frees a slot, which keeps the read pipe at 1 byte/cycle;
  // a full FIFO never issues so buffered + outstanding stays at most 2.
  assign w_inflight = {1'b0, r_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_issue    = (r_state == S_DUMP) && (r_count < r_len) &&
                      (r_occ != 2'd2) && (w_inflight < 3'd2);

  assign cmd_ready      = r_cmd_ready;
  assign in_ready       = r_in_ready;
  assign out_valid      = w_out_valid;
  assign out_data       = r_fifo[r_rd_ptr];
  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_clken      = 1'b1;
  assign mem_address    = r_base + r_count[ADDR_W-1:0];
  assign mem_chipselect = w_accept | w_issue;
  assign mem_write      = w_accept;
  assign mem_writedata  = w_accept ? in_data : '0;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_pop_cnt   <= '0;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_base      <= cmd_base;
            r_len       <= cmd_len;
            r_count     <= '0;
            r_pop_cnt   <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (cmd_op) begin
              r_state <= S_DUMP;
            end else begin
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_count <= r_count + c_one;
            if (r_count == r_len - c_one) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (w_issue) r_count <= r_count + c_one;
          if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + c_one;
            if (r_pop_cnt == r_len - c_one) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after the issue and is pushed unconditionally.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_occ     <= 2'd0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      if (r_rd_pend) begin
        r_fifo[r_wr_ptr] <= mem_readdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, r_rd_pend} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qtestpd_mem_stream_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_qtestpd_mem_stream_master
// Purpose  : Directed self-checking bench with a latency-1 memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qtestpd_mem_stream_master;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [6:0] cmd_base = '0;
  logic [7:0] cmd_len = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic [6:0] mem_address;
  logic       mem_clken;
  logic       mem_chipselect;
  logic       mem_write;
  logic [7:0] mem_writedata;
  logic [7:0] mem_readdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem     [128];
  logic [7:0] exp_mem [128];

  qtestpd_mem_stream_master #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done),
    .mem_address(mem_address), .mem_clken(mem_clken),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  // Memory slave model: synchronous write, registered read (latency 1).
  always @(posedge clk_clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else           mem_readdata     <= mem[mem_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cs"}, mem_chipselect, 0);
    chk({tag, "_write"}, mem_write, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_wdata"}, mem_writedata, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_clken"}, mem_clken, 1);
  endtask

  // Returns on the negedge of the first cycle after acceptance.
  task automatic issue_cmd(input logic op, input logic [6:0] base, input logic [7:0] len);
    @(negedge clk_clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    @(negedge clk_clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_done_cs"}, mem_chipselect, 0);
    @(negedge clk_clk);
    #1;
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_busy_clear"}, busy, 0);
  endtask

  task automatic do_fill(input logic [6:0] base, input int len, input bit gaps,
                         input logic [7:0] seed);
    int k = 0;
    int c = 0;
    logic [6:0] a;
    while (k < len && c < 1000) begin
      if (c > 0) @(negedge clk_clk);
      a = base + 7'(k);
      in_valid = !(gaps && (c % 5 == 3));
      in_data  = seed + 8'(k * 17);
      #1;
      chk("fill_in_ready", in_ready, 1);
      if (in_valid) begin
        chk("fill_cs", mem_chipselect, 1);
        chk("fill_write", mem_write, 1);
        chk("fill_addr", mem_address, a);
        chk("fill_wdata", mem_writedata, in_data);
        exp_mem[a] = in_data;
        k++;
      end else begin
        chk("fill_gap_cs", mem_chipselect, 0);
      end
      c++;
    end
    chk("fill_complete", k, len);
    finish_cmd("fill");
  endtask

  // mode 0: out_ready held high; mode 1: out_ready follows 1,0,0,1,0,1 repeating.
  task automatic do_dump(input logic [6:0] base, input int len, input int mode,
                         input bit chk_lat);
    logic [5:0] pat = 6'b101001;
    int k = 0;
    int c = 0;
    int issued = 0;
    int popped = 0;
    int buffered;
    bit pend_last = 0;
    logic [6:0] a;
    while (k < len && c < 1000) begin
      if (c > 0) @(negedge clk_clk);
      out_ready = (mode == 0) ? 1'b1 : pat[c % 6];
      #1;
      if (chk_lat && c < 2)  chk("dump_latency_invalid", out_valid, 0);
      if (chk_lat && c == 2) chk("dump_latency_valid", out_valid, 1);
      buffered = issued - popped - int'(pend_last);
      if (buffered == 2) chk("dump_no_cs_full", mem_chipselect, 0);
      if (mem_chipselect) begin
        a = base + 7'(issued);
        chk("dump_read_write", mem_write, 0);
        chk("dump_addr", mem_address, a);
        issued++;
      end
      if (out_valid && out_ready) begin
        a = base + 7'(k);
        chk("dump_data", out_data, exp_mem[a]);
        popped++;
        k++;
      end
      chk("dump_inflight_le2", (issued - popped) <= 2, 1);
      pend_last = mem_chipselect;
      c++;
    end
    chk("dump_complete", k, len);
    chk("dump_issued", issued, len);
    finish_cmd("dump");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end

    @(negedge clk_clk);
    #1 chk_reset_values("reset");
    @(negedge clk_clk);
    reset_reset = 1'b0;

    // FILL 0x10 x4 with A1,B2,C3,D4 then read it back two ways.
    issue_cmd(1'b0, 7'h10, 8'd4);
    do_fill(7'h10, 4, 1'b0, 8'hA1);
    chk("mem_10", mem[7'h10], 8'hA1);
    chk("mem_13", mem[7'h13], 8'hD4);
    issue_cmd(1'b1, 7'h10, 8'd4);
    do_dump(7'h10, 4, 0, 1'b1);
    issue_cmd(1'b1, 7'h10, 8'd4);
    do_dump(7'h10, 4, 1, 1'b0);

    // Address wrap 7E,7F,00,01.
    issue_cmd(1'b0, 7'h7E, 8'd4);
    do_fill(7'h7E, 4, 1'b0, 8'h3C);
    chk("mem_wrap_00", mem[7'h00], 8'h3C + 8'd34);
    issue_cmd(1'b1, 7'h7E, 8'd4);
    do_dump(7'h7E, 4, 0, 1'b0);

    // Zero-length command; a command offered while busy is refused.
    issue_cmd(1'b1, 7'h20, 8'd0);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 8'd4;
    #1;
    chk("len0_done", done, 1);
    chk("len0_cs", mem_chipselect, 0);
    chk("busy_cmd_ready", cmd_ready, 0);
    @(negedge clk_clk);
    cmd_valid = 1'b0;
    #1;
    chk("len0_idle_busy", busy, 0);
    chk("len0_idle_done", done, 0);
    chk("len0_idle_cs", mem_chipselect, 0);

    // Full-memory FILL with gaps, full DUMP.
    issue_cmd(1'b0, 7'h40, 8'd128);
    do_fill(7'h40, 128, 1'b1, 8'h07);
    issue_cmd(1'b1, 7'h40, 8'd128);
    do_dump(7'h40, 128, 0, 1'b1);

    // Reset in the middle of a DUMP.
    issue_cmd(1'b1, 7'h40, 8'd128);
    out_ready = 1'b1;
    repeat (4) @(negedge clk_clk);
    reset_reset = 1'b1;
    #1 chk_reset_values("midreset");
    out_ready = 1'b0;
    @(negedge clk_clk);
    #1 chk("midreset_no_done", done, 0);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    #1 chk("post_reset_no_done", done, 0);
    chk("post_reset_busy", busy, 0);
    issue_cmd(1'b1, 7'h40, 8'd4);
    do_dump(7'h40, 4, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
